// File: rtl/mel_log_pkg.sv
// mel_log_pkg: shared constants, FSM encoding and log2 correction table for mel_log.
package mel_log_pkg;
    localparam int N_MEL_DEF = 64;
    localparam int I_BW_DEF  = 14;
    localparam int O_BW_DEF  = 14;
    localparam int Q_INT     = 4;
    localparam int BIN_W     = 6;
    localparam int GRP_W     = 7;
    localparam int CORR_FRAC = 10;

    typedef enum logic {IDLE, RUN} state_t;

    // log2(1+f)-f sampled at the centre of each of 16 fraction segments, in units of 2^-10
    localparam int CORR_Q10 [16] = '{13, 36, 54, 68, 78, 84, 88, 88, 85, 81, 73, 64, 53, 40, 25, 9};

    function automatic int corr(input logic [3:0] idx, input int f);
        return (CORR_Q10[idx] << f) >> CORR_FRAC;
    endfunction
endpackage

// File: rtl/log2_fx.sv
// log2_fx: two-stage fixed-point log2 (leading-one detect, then normalize/fraction).
// MEL_LOG_INTERP_EN adds a segment correction to the truncated fraction.
module log2_fx
    import mel_log_pkg::*;
#(
    parameter int I_BW = I_BW_DEF,
    parameter int O_BW = O_BW_DEF,
    parameter int SB_W = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [I_BW-1:0] x,
    input  logic                   vin,
    input  logic [SB_W-1:0]        sb_i,
    output logic [O_BW-1:0]        y,
    output logic                   vout,
    output logic [SB_W-1:0]        sb_o
);
    localparam int F  = O_BW - Q_INT;
    localparam int PW = $clog2(I_BW);

    logic [PW-1:0]   lod, p_q;
    logic [I_BW-1:0] x_q;
    logic            z_q, v_q;
    logic [SB_W-1:0] sb_q;
    logic [F-1:0]    frac;
    logic [O_BW-1:0] res;

    always_comb begin
        lod = '0;
        for (int i = 0; i < I_BW; i++)
            if (x[i]) lod = PW'(i);
    end

    // shift the leading one to the top, then keep the F bits just below it
    assign frac = F'(({x_q, {F{1'b0}}} << (PW'(I_BW - 1) - p_q)) >> (I_BW - 1));
`ifdef MEL_LOG_INTERP_EN
    assign res = {Q_INT'(p_q), frac} + O_BW'(corr(frac[F-1 -: 4], F));
`else
    assign res = {Q_INT'(p_q), frac};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q  <= '0;
            x_q  <= '0;
            z_q  <= 1'b1;
            v_q  <= 1'b0;
            sb_q <= '0;
            y    <= '0;
            vout <= 1'b0;
            sb_o <= '0;
        end else begin
            p_q  <= lod;
            x_q  <= x;
            z_q  <= x < 2;
            v_q  <= vin;
            sb_q <= sb_i;
            y    <= z_q ? '0 : res;
            vout <= v_q;
            sb_o <= sb_q;
        end
    end
endmodule

// File: rtl/mel_log.sv
// mel_log: double-buffered mel vector serializer feeding a per-bin log2 pipeline.
// MEL_LOG_INTERP_EN selects the corrected log2 fraction in log2_fx.
module mel_log
    import mel_log_pkg::*;
#(
    parameter int I_BW  = I_BW_DEF,
    parameter int O_BW  = O_BW_DEF,
    parameter int N_MEL = N_MEL_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [I_BW*N_MEL-1:0]  data_i,
    input  logic                   di_en,
    input  logic [GRP_W-1:0]       in_group_num,
    output logic [O_BW-1:0]        data_o,
    output logic                   do_en,
    output logic [BIN_W-1:0]       out_bin_idx,
    output logic [GRP_W-1:0]       out_group_num,
    output logic                   is_last_out,
    output logic                   ovf_o
);
    localparam int SB_W = BIN_W + GRP_W + 1;

    state_t                  state, state_n;
    logic [I_BW*N_MEL-1:0]   act, pend;
    logic [GRP_W-1:0]        act_grp, pend_grp;
    logic                    pend_full;
    logic [BIN_W-1:0]        bin;
    logic                    last, load_act, act_src_in, load_pend, drop;
    logic signed [I_BW-1:0]  iss_x;
    logic                    iss_v, iss_last;
    logic [BIN_W-1:0]        iss_idx;
    logic [GRP_W-1:0]        iss_grp;
    logic [SB_W-1:0]         sb_out;

    assign last = state == RUN && bin == BIN_W'(N_MEL - 1);

    // a vector arriving with the final bin takes over directly when nothing is pending
    always_comb begin
        state_n    = state;
        load_act   = 1'b0;
        act_src_in = 1'b0;
        load_pend  = 1'b0;
        drop       = 1'b0;
        if (state == IDLE) begin
            if (di_en) begin
                state_n    = RUN;
                load_act   = 1'b1;
                act_src_in = 1'b1;
            end
        end else if (last) begin
            if (pend_full) begin
                load_act  = 1'b1;
                load_pend = di_en;
            end else if (di_en) begin
                load_act   = 1'b1;
                act_src_in = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end else if (di_en) begin
            drop      = pend_full;
            load_pend = !pend_full;
        end
    end

    always_ff @(posedge clk) begin
        if (load_act) begin
            act     <= act_src_in ? data_i : pend;
            act_grp <= act_src_in ? in_group_num : pend_grp;
        end
        if (load_pend) begin
            pend     <= data_i;
            pend_grp <= in_group_num;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend_full <= 1'b0;
            bin       <= '0;
            ovf_o     <= 1'b0;
            iss_v     <= 1'b0;
            iss_x     <= '0;
            iss_idx   <= '0;
            iss_grp   <= '0;
            iss_last  <= 1'b0;
        end else begin
            state     <= state_n;
            pend_full <= load_pend ? 1'b1 : (load_act && !act_src_in) ? 1'b0 : pend_full;
            bin       <= (state == RUN && !last) ? bin + 1'b1 : '0;
            ovf_o     <= ovf_o | drop;
            iss_v     <= state == RUN;
            iss_x     <= act[bin*I_BW +: I_BW];
            iss_idx   <= bin;
            iss_grp   <= act_grp;
            iss_last  <= last;
        end
    end

    log2_fx #(.I_BW(I_BW), .O_BW(O_BW), .SB_W(SB_W)) u_log2 (
        .clk  (clk),
        .rst  (rst),
        .x    (iss_x),
        .vin  (iss_v),
        .sb_i ({iss_idx, iss_grp, iss_last}),
        .y    (data_o),
        .vout (do_en),
        .sb_o (sb_out)
    );

    assign {out_bin_idx, out_group_num, is_last_out} = sb_out;
endmodule

// File: tb/tb_mel_log.sv
// tb_mel_log: directed self-checking bench for mel_log (default build).
module tb_mel_log;
    localparam int IB = 14;
    localparam int N  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IB*N-1:0]   data_i = '0;
    logic              di_en = 1'b0;
    logic [6:0]        in_group_num = '0;
    logic [13:0]       data_o;
    logic              do_en;
    logic [5:0]        out_bin_idx;
    logic [6:0]        out_group_num;
    logic              is_last_out;
    logic              ovf_o;

    int checks = 0;
    int errors = 0;

    mel_log dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .di_en         (di_en),
        .in_group_num  (in_group_num),
        .data_o        (data_o),
        .do_en         (do_en),
        .out_bin_idx   (out_bin_idx),
        .out_group_num (out_group_num),
        .is_last_out   (is_last_out),
        .ovf_o         (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string t, input logic e, input int idx, input int g,
                              input int val, input logic lst);
        chk({t, " do_en"}, 32'(do_en), 32'(e));
        if (e) begin
            chk({t, " idx"}, 32'(out_bin_idx), 32'(idx));
            chk({t, " grp"}, 32'(out_group_num), 32'(g));
            chk({t, " data"}, 32'(data_o), 32'(val));
            chk({t, " last"}, 32'(is_last_out), 32'(lst));
        end
    endtask

    function automatic logic [IB*N-1:0] fill(input int v);
        logic [IB*N-1:0] r;
        for (int k = 0; k < N; k++) r[k*IB +: IB] = IB'(v);
        return r;
    endfunction

    task automatic send(input logic [IB*N-1:0] v, input int g);
        data_i       = v;
        in_group_num = 7'(g);
        di_en        = 1'b1;
        tick();
        di_en        = 1'b0;
    endtask

    // vector A (all 2, frame 1) at c=0; vector B (all 8, frame 2) at c=g2; vector C at c=g3
    task automatic stream(input int g2, input int g3);
        logic e;
        send(fill(2), 1);
        for (int c = 1; c <= 134; c++) begin
            di_en        = (c == g2) || (c == g3);
            data_i       = (c == g2) ? fill(8) : fill(1000);
            in_group_num = (c == g2) ? 7'd2 : 7'd3;
            tick();
            e = c >= 3 && c <= 130;
            expect_out("stream", e, (c - 3) % 64, c < 67 ? 1 : 2, c < 67 ? 1024 : 3072,
                       ((c - 3) % 64) == 63);
            chk("stream ovf", 32'(ovf_o), 32'(g3 > 0 && c >= g3));
        end
        di_en = 1'b0;
    endtask

    initial begin
        logic [IB*N-1:0] vec;
        int exp36 [7];
        int n;
        repeat (3) tick();
        chk("rst do_en", 32'(do_en), 0);
        chk("rst data", 32'(data_o), 0);
        chk("rst idx", 32'(out_bin_idx), 0);
        chk("rst grp", 32'(out_group_num), 0);
        chk("rst last", 32'(is_last_out), 0);
        chk("rst ovf", 32'(ovf_o), 0);
        rst = 1'b0;
        tick();

        // all bins 1000: leading one at 9, fraction 976/1024
        send(fill(1000), 5);
        tick();
        tick();
        chk("lat early", 32'(do_en), 0);
        for (int k = 0; k < N; k++) begin
            tick();
            expect_out("b1000", 1'b1, k, 5, 10192, k == 63);
        end
        tick();
        chk("b1000 end", 32'(do_en), 0);

        vec = fill(0);
        vec[0*IB +: IB] = 14'd0;
        vec[1*IB +: IB] = -14'sd5;
        vec[2*IB +: IB] = 14'd1;
        vec[3*IB +: IB] = 14'd2;
        vec[4*IB +: IB] = 14'd8191;
        vec[5*IB +: IB] = 14'd3;
        vec[6*IB +: IB] = 14'd4096;
        exp36 = '{0, 0, 0, 1024, 13311, 1536, 12288};
        send(vec, 9);
        repeat (2) tick();
        for (int k = 0; k < N; k++) begin
            tick();
            expect_out("edge", 1'b1, k, 9, k < 7 ? exp36[k] : 0, k == 63);
        end
        repeat (3) tick();

        stream(10, -1);
        stream(64, -1);
        stream(1, 2);

        send(fill(2), 20);
        repeat (33) tick();
        expect_out("pre rst", 1'b1, 30, 20, 1024, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst do_en", 32'(do_en), 0);
        chk("mid rst data", 32'(data_o), 0);
        chk("mid rst idx", 32'(out_bin_idx), 0);
        chk("mid rst grp", 32'(out_group_num), 0);
        chk("mid rst last", 32'(is_last_out), 0);
        chk("mid rst ovf", 32'(ovf_o), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post rst quiet", 32'(do_en), 0);
        end
        send(fill(8), 21);
        tick();
        tick();
        chk("post rst lat early", 32'(do_en), 0);
        tick();
        expect_out("post rst bin0", 1'b1, 0, 21, 3072, 1'b0);
        repeat (70) tick();

        n = 0;
        for (int f = 0; f < 89; f++) begin
            for (int c = 0; c < 513; c++) begin
                di_en        = c == 0;
                data_i       = fill(1000);
                in_group_num = 7'(f);
                tick();
                if (do_en) begin
                    chk("frame grp", 32'(out_group_num), 32'(n / 64));
                    chk("frame idx", 32'(out_bin_idx), 32'(n % 64));
                    n++;
                end
            end
        end
        di_en = 1'b0;
        repeat (8) begin
            tick();
            if (do_en) n++;
        end
        chk("frame count", 32'(n), 5696);
        chk("frame ovf", 32'(ovf_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
